// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end.
// Issues one word read per cycle while the decode-side buffer has room. The
// read response arrives one cycle later and is pushed into a 2-entry
// {pc,instr} FIFO. Redirects flush the FIFO, drop any in-flight response and
// restart fetch at the new target.
// Optional build macro: FETCH_PERF_EN adds the perf_fetched / perf_stall
// counter outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  // Buffer depth; the pointer and count widths below are sized for 2 only.
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  // Architectural state
  logic [31:0] pc_reg, pc_next;
  logic [31:0] issued_pc_reg;
  logic [1:0]  count_reg, count_next;
  logic        inflight_reg, inflight_next;
  logic        kill_reg, kill_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;

  // Buffer storage
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];

  // Handshake / control terms
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  credit;
  logic [31:0] redirect_target;

  assign instr_valid     = (count_reg != 2'd0);
  assign pop             = instr_valid & dec_ready;
  // Slots not yet claimed by buffered or in-flight words; a pop this cycle
  // frees its slot in time for the new response.
  assign credit          = 3'd2 - ({1'b0, count_reg} + {2'b00, inflight_reg}) + {2'b00, pop};
  // No issue while in reset or during a redirect; credit[2] would only be set
  // if the occupancy invariant were broken, so treat it as "no room".
  assign issue           = rstn & ~redirect_valid & (credit != 3'd0) & ~credit[2];
  // A response is dropped if it belongs to a killed window or a redirect
  // lands in the same cycle it returns.
  assign push            = inflight_reg & ~kill_reg & ~redirect_valid;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  assign imem_req  = issue;
  assign imem_addr = pc_reg;

  // Head of buffer drives decode straight from registers.
  assign instr    = fifo_instr[rd_ptr_reg];
  assign instr_pc = fifo_pc[rd_ptr_reg];
  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];

  // Next-state computation for PC, occupancy, pointers and in-flight tracking
  always_comb begin
    pc_next       = pc_reg;
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    inflight_next = issue;
    kill_next     = redirect_valid;

    if (redirect_valid) begin
      // Flush everything; the head (if popped this cycle) was already taken.
      pc_next     = redirect_target;
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
    end else begin
      if (issue) begin
        // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
        pc_next = pc_reg + 32'd4;
      end
      count_next  = count_reg + {1'b0, push} - {1'b0, pop};
      rd_ptr_next = rd_ptr_reg ^ pop;
      wr_ptr_next = wr_ptr_reg ^ push;
    end
  end

  // State register for PC, occupancy, pointers and in-flight tracking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_reg        <= RESET_PC;
      issued_pc_reg <= 32'd0;
      count_reg     <= 2'd0;
      inflight_reg  <= 1'b0;
      kill_reg      <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      kill_reg     <= kill_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      if (issue) begin
        issued_pc_reg <= pc_reg;
      end
    end
  end

  // Per-entry buffer write; entries clear on reset so the head reads zero
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture returning word into this slot when the write pointer selects it
      always_ff @(posedge clk) begin
        if (!rstn) begin
          fifo_pc[gi]    <= 32'd0;
          fifo_instr[gi] <= 32'd0;
        end else if (push && (wr_ptr_reg == gi[0])) begin
          fifo_pc[gi]    <= issued_pc_reg;
          fifo_instr[gi] <= imem_rdata;
        end
      end
    end
  endgenerate

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  // Count accepted responses and cycles where decode holds off a valid head
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_fetched_reg <= 32'd0;
      perf_stall_reg   <= 32'd0;
    end else begin
      if (push) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (instr_valid && !dec_ready) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

  // Credit accounting must never leave a full buffer with a read outstanding.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !((count_reg == 2'd2) && inflight_reg) && (count_reg != 2'd3));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit with a one-cycle-latency memory
// whose word at byte address a is a>>2. A second instance with
// RESET_PC=32'hFFFF_FFF8 covers PC wraparound and decoder field slicing.
module tb_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        imem_req_b;
  logic [31:0] imem_addr_b;
  logic [31:0] imem_rdata_b;
  logic        instr_valid_b;
  logic [31:0] instr_b;
  logic [31:0] instr_pc_b;
  logic [6:0]  op_b;
  logic [2:0]  funct3_b;
  logic [6:0]  funct7_b;
  logic        dec_ready_b;
  logic        redirect_valid_b;
  logic [31:0] redirect_pc_b;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_fetched_b;
  logic [31:0] perf_stall_b;
`endif

  int total;
  int bad;
  int cyc_n;

  logic [31:0] exp_b_pc    [3];
  logic [31:0] exp_b_instr [3];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_ready(dec_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .op(op), .funct3(funct3), .funct7(funct7)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
    .clk(clk), .rstn(rstn),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .dec_ready(dec_ready_b),
    .instr_valid(instr_valid_b), .instr(instr_b), .instr_pc(instr_pc_b),
    .op(op_b), .funct3(funct3_b), .funct7(funct7_b)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched_b), .perf_stall(perf_stall_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read memory; junk on idle cycles exposes spurious pushes.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? (imem_addr   >> 2) : 32'hDEAD_BEEF;
    imem_rdata_b <= imem_req_b ? (imem_addr_b >> 2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc_n, got, exp);
    end
  endtask

  // Advance one clock, then apply inputs for the new cycle and let them settle.
  task automatic cyc(input logic r, input logic dr, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rstn           = r;
    dec_ready      = dr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    cyc_n++;
    $display("cyc %0d rstn=%0b req=%0b addr=%h valid=%0b pc=%h instr=%h",
             cyc_n, rstn, imem_req, imem_addr, instr_valid, instr_pc, instr);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc_n = -4;
    exp_b_pc[0]    = 32'hFFFF_FFF8; exp_b_instr[0] = 32'h3FFF_FFFE;
    exp_b_pc[1]    = 32'hFFFF_FFFC; exp_b_instr[1] = 32'h3FFF_FFFF;
    exp_b_pc[2]    = 32'h0000_0000; exp_b_instr[2] = 32'h0000_0000;
    rstn             = 1'b0;
    dec_ready        = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'd0;
    dec_ready_b      = 1'b1;
    redirect_valid_b = 1'b0;
    redirect_pc_b    = 32'd0;

    // Reset: three cycles with rstn low (cycles -3..-1)
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("rst_req",    {31'd0, imem_req},    32'd0);
    chk("rst_valid",  {31'd0, instr_valid}, 32'd0);
    chk("rst_instr",  instr,                32'd0);
    chk("rst_pc",     instr_pc,             32'd0);
    chk("rst_fields", {18'd0, op, funct3, funct7}, 32'd0);
    chk("rst_b_valid", {31'd0, instr_valid_b}, 32'd0);

    // Streaming from reset, cycles 0..5
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      chk("str_req",  {31'd0, imem_req}, 32'd1);
      chk("str_addr", imem_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("str_valid", {31'd0, instr_valid}, 32'd1);
        chk("str_pc",    instr_pc, 32'(4 * (k - 2)));
        chk("str_instr", instr,    32'(k - 2));
      end else begin
        chk("str_nvalid", {31'd0, instr_valid}, 32'd0);
        chk("b_nvalid",   {31'd0, instr_valid_b}, 32'd0);
      end
      if (k == 0) chk("b_addr0", imem_addr_b, 32'hFFFF_FFF8);
      if (k >= 2 && k <= 4) begin
        chk("b_pc",    instr_pc_b, exp_b_pc[k - 2]);
        chk("b_instr", instr_b,    exp_b_instr[k - 2]);
      end
      if (k == 2) begin
        chk("b_op",     {25'd0, op_b},     32'h7E);
        chk("b_funct3", {29'd0, funct3_b}, 32'h7);
        chk("b_funct7", {25'd0, funct7_b}, 32'h1F);
      end
    end

    // Decode stall for five cycles (6..10): head holds at 16, no issue
    for (int k = 6; k < 11; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      chk("stl_req",   {31'd0, imem_req},    32'd0);
      chk("stl_valid", {31'd0, instr_valid}, 32'd1);
      chk("stl_pc",    instr_pc, 32'd16);
    end

    // Resume (11..14): consecutive PCs, fetch restarts at 24
    for (int k = 11; k < 15; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      chk("res_pc",    instr_pc, 32'(16 + 4 * (k - 11)));
      chk("res_instr", instr,    32'(4 + (k - 11)));
      if (k == 11) begin
        chk("res_req",  {31'd0, imem_req}, 32'd1);
        chk("res_addr", imem_addr, 32'd24);
`ifdef FETCH_PERF_EN
        chk("perf_stall",   perf_stall,   32'd5);
        chk("perf_fetched", perf_fetched, 32'd6);
`endif
      end
    end

    // Fill the buffer (15), then redirect to 0x103 while full (16)
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    chk("fill_req", {31'd0, imem_req}, 32'd0);
    chk("fill_pc",  instr_pc, 32'd32);
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("rd_req",   {31'd0, imem_req},    32'd0);
    chk("rd_valid", {31'd0, instr_valid}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("rd_empty", {31'd0, instr_valid}, 32'd0);
    chk("rd_req2",  {31'd0, imem_req},    32'd1);
    chk("rd_addr",  imem_addr, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("rd_empty2", {31'd0, instr_valid}, 32'd0);
    chk("rd_addr2",  imem_addr, 32'h104);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      chk("rd_valid3", {31'd0, instr_valid}, 32'd1);
      chk("rd_pc",     instr_pc, 32'(32'h100 + 4 * k));
      chk("rd_instr",  instr,    32'(32'h40 + k));
    end

    // Back-to-back redirects (21: 0x40 with pop, 22: 0x80); last wins
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    chk("rr_pc",  instr_pc, 32'h108);
    chk("rr_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    chk("rr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rr_req2",  {31'd0, imem_req},    32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("rr_valid2", {31'd0, instr_valid}, 32'd0);
    chk("rr_addr",   imem_addr, 32'h80);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("rr_valid3", {31'd0, instr_valid}, 32'd0);
    chk("rr_addr2",  imem_addr, 32'h84);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      chk("rr_valid4", {31'd0, instr_valid}, 32'd1);
      chk("rr_pc2",    instr_pc, 32'(32'h80 + 4 * k));
      chk("rr_instr",  instr,    32'(32'h20 + k));
    end

    // Reset mid-stream with a read in flight (27, 28), then restart
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("mr_req2",  {31'd0, imem_req},    32'd0);
    chk("mr_valid", {31'd0, instr_valid}, 32'd0);
    chk("mr_instr", instr,    32'd0);
    chk("mr_pc",    instr_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("mr_perf_stall",   perf_stall,   32'd0);
    chk("mr_perf_fetched", perf_fetched, 32'd0);
`endif
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("mr_issue", {31'd0, imem_req}, 32'd1);
    chk("mr_addr",  imem_addr, 32'd0);
    chk("mr_nvalid", {31'd0, instr_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("mr_nvalid2", {31'd0, instr_valid}, 32'd0);
    chk("mr_addr2",   imem_addr, 32'd4);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'd0);
      chk("mr_valid2", {31'd0, instr_valid}, 32'd1);
      chk("mr_pc2",    instr_pc, 32'(4 * k));
      chk("mr_instr2", instr,    32'(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries; only 2 is supported.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rstn  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port imem_req  out  1  instruction-memory read strobe.
REQ-006 SHALL have port imem_addr  out  32  byte address of read, bits[1:0]=0.
REQ-007 SHALL have port imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
REQ-008 SHALL have port redirect_valid  in  1  branch/jump redirect from execute.
REQ-009 SHALL have port redirect_pc  in  32  redirect target, bits[1:0] ignored.
REQ-010 SHALL have port dec_ready  in  1  decode accepts head instruction (low on hazard or FPU stall).
REQ-011 SHALL have port instr_valid  out  1  buffer head valid.
REQ-012 SHALL have port instr  out  32  head instruction word.
REQ-013 SHALL have port instr_pc  out  32  PC of head instruction.
REQ-014 SHALL have ports op  out  7, funct3  out  3, funct7  out  7: slices instr[6:0], instr[14:12], instr[31:25] for the decoder.

Function
REQ-015 SHALL hold fetch PC, 2-entry FIFO of {pc,instr}, count (0..2), in-flight flag, kill flag.
REQ-016 SHALL compute credit = 2 - count - inflight + pop, where pop = instr_valid & dec_ready.
REQ-017 SHALL assert imem_req with imem_addr=PC when credit>0 and no redirect this cycle; PC <= PC+4 on issue, wrapping 32'hFFFF_FFFC to 0.
REQ-018 SHALL, one cycle after issue, push {issued PC, imem_rdata} unless killed; inflight cleared.
REQ-019 SHALL drive instr_valid = (count!=0), instr/instr_pc from head, registered outputs only (no memory-to-decode bypass).
REQ-020 SHALL complete handshake on instr_valid & dec_ready; head removed same edge; simultaneous push and pop keeps count unchanged.
REQ-021 SHALL never drop or duplicate an instruction while dec_ready is low; issue stops when credit=0.
REQ-022 SHALL on redirect_valid: complete any same-cycle pop, flush all remaining entries, kill in-flight response, suppress imem_req, load PC <= {redirect_pc[31:2],2'b00}.
REQ-023 SHALL issue redirect target the cycle after redirect; first instr_valid at target two cycles after that issue.
REQ-024 SHALL treat redirect in consecutive cycles as last-wins; earlier target never appears.
REQ-025 SHALL sustain one instruction per cycle with dec_ready held high after initial 2-cycle fill.
REQ-026 SHALL, with count=2 and inflight=1 impossible by construction, flag it as an assertion.

Reset
REQ-027 SHALL on rstn=0 at rising edge: PC=RESET_PC, count=0, inflight=0, kill=0, FIFO pointers 0.
REQ-028 SHALL drive imem_req=0, instr_valid=0 during reset; instr/instr_pc/op/funct3/funct7 = 0.
REQ-029 SHALL discard any response arriving the first cycle after reset release.
REQ-030 SHALL issue RESET_PC in the first cycle rstn=1; instr_valid first high two cycles later.

Configuration
REQ-031 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetched[31:0] (count of pushes) and perf_stall[31:0] (cycles instr_valid & ~dec_ready), both wrapping, reset to 0.
REQ-032 SHALL, without FETCH_PERF_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-033 Reset release, dec_ready=1, memory word i = i -> imem_addr 0,4,8..., instr_valid from cycle 2, instr 0,1,2 one per cycle, instr_pc 0,4,8.
REQ-034 dec_ready low 5 cycles after first valid -> count saturates at 2, imem_req low, resume yields consecutive PCs with no gap/duplicate.
REQ-035 redirect_valid with redirect_pc=32'h0000_0103 while FIFO full -> FIFO empty next cycle, next imem_addr 32'h100, first instr_pc 32'h100, no stale word delivered.
REQ-036 Redirects to 0x40 then 0x80 on consecutive cycles -> only 0x80 stream delivered.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rstn low mid-stream with in-flight read -> outputs zero, restart at RESET_PC, old word never appears; with FETCH_PERF_EN, perf_stall equals stalled cycles (5 in REQ-034).
